// File: rtl/fetch_stage.sv
// Instruction-fetch front end: credit-limited in-order requests to instruction memory,
// a small {PC, instr} buffer towards Decode, and redirect handling that kills in-flight fetches.
module fetch_stage #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     FIFO_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic            instr_valid,
  input  logic            instr_ready
);
  localparam int unsigned   CW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned   PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]     r_fifo_instr [FIFO_DEPTH];

  logic [XLEN-1:0] w_target;
  logic            w_credit_ok;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_ok;
  logic            w_push;
  logic            w_pop;
  logic            w_instr_valid;
  logic [CW-1:0]   w_outst_nxt;
  logic [CW-1:0]   w_discard_nxt;
  logic [CW-1:0]   w_count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Credits cover both in-flight requests and buffered words, so the buffer cannot overflow.
  assign w_target      = redirect_target & ~(XLEN'(2'b11));
  assign w_credit_ok   = ({1'b0, r_outst} + {1'b0, r_count}) < {1'b0, DEPTH_C};
  assign w_req_valid   = !reset && !redirect_valid && w_credit_ok;
  assign w_req_fire    = w_req_valid && imem_req_ready;
  assign w_rsp_ok      = imem_rsp_valid && (r_outst != '0);
  assign w_push        = w_rsp_ok && (r_discard == '0) && !redirect_valid;
  assign w_instr_valid = (r_count != '0) && !redirect_valid;
  assign w_pop         = w_instr_valid && instr_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign instr_valid    = w_instr_valid;
  assign InstrD         = r_fifo_instr[r_rd_ptr];
  assign PCD            = r_fifo_pc[r_rd_ptr];

  // Next values of the outstanding, discard and occupancy counters.
  always_comb begin
    w_outst_nxt   = r_outst;
    w_discard_nxt = r_discard;
    w_count_nxt   = r_count;
    case ({w_req_fire, w_rsp_ok})
      2'b10:   w_outst_nxt = r_outst + CW'(1'b1);
      2'b01:   w_outst_nxt = r_outst - CW'(1'b1);
      default: w_outst_nxt = r_outst;
    endcase
    if (redirect_valid) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      w_discard_nxt = r_outst - CW'(w_rsp_ok);
      w_count_nxt   = '0;
    end else begin
      if (w_rsp_ok && (r_discard != '0)) begin
        w_discard_nxt = r_discard - CW'(1'b1);
      end else begin
        w_discard_nxt = r_discard;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1'b1);
        2'b01:   w_count_nxt = r_count - CW'(1'b1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // PCs, counters and buffer storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_VECTOR;
      r_rsp_pc  <= RESET_VECTOR;
      r_outst   <= '0;
      r_discard <= '0;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_pc[i]    <= RESET_VECTOR;
        r_fifo_instr[i] <= '0;
      end
    end else begin
      r_outst   <= w_outst_nxt;
      r_discard <= w_discard_nxt;
      r_count   <= w_count_nxt;
      if (redirect_valid) begin
        r_pc     <= w_target;
        r_rsp_pc <= w_target;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + XLEN'(3'd4);
        end
        if (w_push) begin
          r_rsp_pc                <= r_rsp_pc + XLEN'(3'd4);
          r_fifo_pc[r_wr_ptr]     <= r_rsp_pc;
          r_fifo_instr[r_wr_ptr]  <= imem_rsp_data;
          r_wr_ptr                <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order instruction memory model with configurable latency and
// a PC-stream reference (next request / next delivered PC restart at each redirect target).
module tb_fetch_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic            instr_valid;
  logic            instr_ready;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .InstrD(InstrD), .PCD(PCD), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int base_cyc = 0;
  int first_pop = -1;
  int lat      = 1;
  int n_acc    = 0;
  int n_pop    = 0;
  int q_due[$];
  logic [31:0] q_addr[$];

  logic        obs_req, obs_acc, obs_iv, obs_pop, obs_rsp, obs_redir;
  logic [31:0] obs_addr, obs_pcd, obs_instr, obs_tgt;
  logic [31:0] exp_req, exp_out;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // One clock: sample at negedge, update the memory model, drive the next response after posedge.
  task automatic tick();
    @(negedge clk);
    obs_req   = imem_req_valid;
    obs_addr  = imem_req_addr;
    obs_acc   = imem_req_valid && imem_req_ready;
    obs_iv    = instr_valid;
    obs_pop   = instr_valid && instr_ready;
    obs_pcd   = PCD;
    obs_instr = InstrD;
    obs_rsp   = imem_rsp_valid;
    obs_redir = redirect_valid && !reset;
    obs_tgt   = redirect_target;
    if (obs_pop && first_pop < 0) first_pop = cyc;
    if (obs_pop) n_pop++;
    if (obs_rsp && q_due.size() > 0) begin
      void'(q_due.pop_front());
      void'(q_addr.pop_front());
    end
    if (obs_acc) begin
      q_due.push_back(cyc + lat);
      q_addr.push_back(obs_addr);
      n_acc++;
    end
    if (reset) begin
      q_due.delete();
      q_addr.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(q_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_req = 32'h0;
    exp_out = 32'h0;
    base_cyc = cyc;
    first_pop = -1;
  endtask

  // Random traffic segment checked against the PC-stream reference.
  task automatic run_stream(input int n, input int rdy_pct, input int irdy_pct, input int redir_pct);
    logic        prev_hold;
    logic [31:0] prev_pcd, prev_instr;
    prev_hold = 1'b0;
    prev_pcd = 32'h0;
    prev_instr = 32'h0;
    for (int i = 0; i < n; i++) begin
      imem_req_ready  = (int'($urandom_range(99)) < rdy_pct);
      instr_ready     = (int'($urandom_range(99)) < irdy_pct);
      redirect_valid  = (int'($urandom_range(99)) < redir_pct);
      redirect_target = $urandom;
      tick();
      if (obs_redir) begin
        n_checks++;
        if (obs_req !== 1'b0 || obs_iv !== 1'b0)
          $display("FAIL redirect_quiet: req_valid=%b instr_valid=%b, want 0/0", obs_req, obs_iv);
        else n_pass++;
        exp_req = obs_tgt & 32'hFFFF_FFFC;
        exp_out = obs_tgt & 32'hFFFF_FFFC;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          n_checks++;
          if (obs_iv !== 1'b1 || obs_pcd !== prev_pcd || obs_instr !== prev_instr)
            $display("FAIL stall_hold: valid=%b PCD=%h InstrD=%h, want 1 %h %h",
                     obs_iv, obs_pcd, obs_instr, prev_pcd, prev_instr);
          else n_pass++;
        end
        if (obs_acc) begin
          n_checks++;
          if (obs_addr !== exp_req)
            $display("FAIL req_addr: got %h want %h", obs_addr, exp_req);
          else n_pass++;
          exp_req += 32'h4;
        end
        if (obs_pop) begin
          n_checks++;
          if (obs_pcd !== exp_out || obs_instr !== memf(exp_out))
            $display("FAIL deliver: PCD=%h InstrD=%h, want %h %h", obs_pcd, obs_instr, exp_out, memf(exp_out));
          else n_pass++;
          exp_out += 32'h4;
        end
        prev_hold  = obs_iv && !obs_pop;
        prev_pcd   = obs_pcd;
        prev_instr = obs_instr;
      end
      n_checks++;
      if (q_due.size() > DEPTH)
        $display("FAIL inflight: %0d outstanding, want <= %0d", q_due.size(), DEPTH);
      else n_pass++;
    end
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs_req !== 1'b0 || obs_iv !== 1'b0 || obs_pcd !== 32'h0 || obs_instr !== 32'h0)
      $display("FAIL reset_state: req=%b valid=%b PCD=%h InstrD=%h, want 0 0 0 0", obs_req, obs_iv, obs_pcd, obs_instr);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0)
      $display("FAIL first_req: req=%b addr=%h, want 1 00000000", obs_req, obs_addr);
    else n_pass++;
  endtask

  task automatic test_sequential();
    int p0;
    lat = 1;
    do_reset();
    p0 = n_pop;
    run_stream(30, 100, 100, 0);
    n_checks++;
    if (first_pop - base_cyc !== 2)
      $display("FAIL first_latency: first valid at cycle %0d, want 2", first_pop - base_cyc);
    else n_pass++;
    n_checks++;
    if (n_pop - p0 < 15) $display("FAIL seq_throughput: %0d words, want >= 15", n_pop - p0);
    else n_pass++;
  endtask

  task automatic test_stall();
    int a0, p0;
    lat = 1;
    do_reset();
    a0 = n_acc;
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 2) begin
        n_checks++;
        if (obs_iv !== 1'b1 || obs_pcd !== 32'h0 || obs_instr !== memf(32'h0))
          $display("FAIL stall_head: valid=%b PCD=%h InstrD=%h, want 1 0 %h", obs_iv, obs_pcd, obs_instr, memf(32'h0));
        else n_pass++;
      end
    end
    n_checks++;
    if (n_acc - a0 !== 2 || obs_req !== 1'b0)
      $display("FAIL stall_credits: accepted=%0d req_valid=%b, want 2 0", n_acc - a0, obs_req);
    else n_pass++;
    exp_req = 32'h8;
    p0 = n_pop;
    run_stream(20, 100, 100, 0);
    n_checks++;
    if (n_pop - p0 < 5) $display("FAIL stall_resume: %0d words, want >= 5", n_pop - p0);
    else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    logic got;
    int   p0;
    lat = 3;
    do_reset();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (obs_acc) begin
        n_checks++;
        if (obs_addr !== exp_req) $display("FAIL inflight_addr: got %h want %h", obs_addr, exp_req);
        else n_pass++;
        exp_req += 32'h4;
      end
      if (q_due.size() == 2) got = 1'b1;
    end
    n_checks++;
    if (got !== 1'b1) $display("FAIL inflight_timeout: outstanding=%0d, want 2", q_due.size());
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_target = 32'h104;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (obs_req !== 1'b0 || obs_iv !== 1'b0)
      $display("FAIL redir_cycle: req=%b valid=%b, want 0 0", obs_req, obs_iv);
    else n_pass++;
    exp_req = 32'h104;
    exp_out = 32'h104;
    p0 = n_pop;
    run_stream(20, 100, 100, 0);
    n_checks++;
    if (n_pop - p0 < 2) $display("FAIL redir_resume: %0d words, want >= 2", n_pop - p0);
    else n_pass++;
  endtask

  task automatic test_redirect_same_cycle();
    int p0;
    lat = 1;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h203;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (obs_rsp !== 1'b1 || obs_req !== 1'b0 || obs_iv !== 1'b0)
      $display("FAIL redir_rsp_cycle: rsp=%b req=%b valid=%b, want 1 0 0", obs_rsp, obs_req, obs_iv);
    else n_pass++;
    exp_req = 32'h200;
    exp_out = 32'h200;
    p0 = n_pop;
    run_stream(15, 100, 100, 0);
    n_checks++;
    if (n_pop - p0 < 1) $display("FAIL redir_rsp_resume: %0d words, want >= 1", n_pop - p0);
    else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    int p0;
    lat = 1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    exp_req = 32'hFFFF_FFFC;
    exp_out = 32'hFFFF_FFFC;
    p0 = n_pop;
    run_stream(8, 100, 100, 0);
    n_checks++;
    if (n_pop - p0 < 3) $display("FAIL wrap_words: %0d words, want >= 3", n_pop - p0);
    else n_pass++;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (obs_req !== 1'b0) $display("FAIL reset_req: req=%b want 0", obs_req);
    else n_pass++;
    tick();
    n_checks++;
    if (obs_req !== 1'b0 || obs_iv !== 1'b0 || obs_pcd !== 32'h0 || obs_instr !== 32'h0)
      $display("FAIL midstall_reset: req=%b valid=%b PCD=%h InstrD=%h, want 0 0 0 0", obs_req, obs_iv, obs_pcd, obs_instr);
    else n_pass++;
    reset = 1'b0;
    instr_ready = 1'b1;
  endtask

  task automatic test_random();
    int p0;
    lat = 1;
    do_reset();
    p0 = n_pop;
    for (int ph = 0; ph < 4; ph++) begin
      lat = int'($urandom_range(3, 1));
      run_stream(500, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 3);
    end
    run_stream(10, 0, 100, 0);
    n_checks++;
    if (obs_req !== 1'b1 || q_due.size() != 0)
      $display("FAIL drain_credits: req=%b outstanding=%0d, want 1 0", obs_req, q_due.size());
    else n_pass++;
    n_checks++;
    if (n_pop - p0 < 100) $display("FAIL random_words: %0d words, want >= 100", n_pop - p0);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    instr_ready = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
